palm_locator: RTL and testbench
===============================

PALM_LOCATOR -- requirements
Module: palm_locator

Interface
REQ-001 Parameter IMG_W, default 160, pixels per row (2..255).
REQ-002 Parameter IMG_H, default 120, rows per frame (2..255).
REQ-003 Parameter MIN_PIX, default 64, minimum foreground pixel count for a valid palm (1..65535).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pix_valid  input  1  pixel offered this cycle.
REQ-007 pix_ready  output  1  block accepts a pixel this cycle; a pixel transfers when pix_valid and pix_ready are both 1.
REQ-008 pix_data  input  1  binary pixel, 1 = foreground (skin).
REQ-009 sof  input  1  start of frame; qualifies the transferred pixel as row 0, column 0.
REQ-010 start_of_palm_r, start_of_palm_c  output  8 each  top row and left column of the palm bounding box.
REQ-011 end_of_palm_r, end_of_palm_c  output  8 each  bottom row and right column of the palm bounding box.
REQ-012 palm_width, palm_height  output  8 each  box size; 0 means no palm.
REQ-013 box_valid  output  1  result registers hold an unconsumed result.
REQ-014 box_ready  input  1  consumer accepts the result; the transfer occurs when box_valid and box_ready are both 1.
REQ-015 frame_err  output  1  one-cycle pulse: frame aborted by an early sof.

Function
REQ-016 FSM states SHALL be IDLE, SCAN and PUBLISH; pix_ready = 1 in IDLE and SCAN, 0 in PUBLISH.
REQ-017 IDLE: transfers without sof are discarded; a transfer with sof is processed as pixel (0,0), and the FSM enters SCAN.
REQ-018 SCAN: each transfer advances the column counter; at IMG_W-1 the column wraps to 0 and the row increments.
REQ-019 Foreground pixel: min_r, min_c, max_r and max_c update to include (row, col); the 16-bit pixel count increments and saturates at 65535.
REQ-020 On the sof transfer, trackers SHALL initialise from that pixel alone (min = max = (0,0) and count = 1 if foreground; count = 0 and trackers empty otherwise).
REQ-021 The transfer at (IMG_H-1, IMG_W-1) ends the frame; the FSM enters PUBLISH on that edge.
REQ-022 A sof transfer in SCAN before frame end SHALL pulse frame_err for one cycle; the partial frame is dropped with no result, and that pixel restarts a new frame at (0,0) in SCAN.
REQ-023 PUBLISH, box_valid = 0 or box_ready = 1: the result registers load on that edge, box_valid is 1 after it, and the FSM returns to IDLE.
REQ-024 PUBLISH, box_valid = 1 and box_ready = 0: the FSM holds PUBLISH and the pixel input stalls.
REQ-025 Latency: the last pixel transfers at edge N; with a free slot, box_valid is 1 after edge N+1.
REQ-026 Result with count >= MIN_PIX: start = (min_r, min_c); end = (max_r, max_c); palm_width = max_c - min_c + 1; palm_height = max_r - min_r + 1.
REQ-027 Result with count < MIN_PIX: all six box outputs = 0, box_valid still asserted.
REQ-028 Box outputs SHALL remain stable while box_valid = 1 and change only on a PUBLISH load.
REQ-029 box_valid SHALL clear after a transfer edge unless a PUBLISH load occurs on that same edge.

Reset
REQ-030 While rst = 0: FSM = IDLE; counters, trackers and count = 0; all box outputs = 0; box_valid = 0; frame_err = 0; pix_ready = 0.
REQ-031 Reset SHALL take effect immediately without clk; deassertion is synchronised internally, and pix_ready rises on the second clk edge after release.
REQ-032 Reset mid-frame or mid-PUBLISH SHALL discard all in-progress data; no result is emitted.

Verification (bench parameters IMG_W=8, IMG_H=6, MIN_PIX=4; box_ready = 1 unless stated)
REQ-033 Foreground rectangle rows 1..3, cols 2..5 streamed without gaps -> box_valid 1 cycle after the last pixel; start (1,2), end (3,5), width 4, height 3.
REQ-034 Only 3 foreground pixels in the frame -> box_valid = 1 with all box outputs 0.
REQ-035 sof at pixel 20 of a frame -> frame_err pulses once with no result; the following full frame reports correctly.
REQ-036 box_ready = 0 with a result pending, then a second frame ends -> pix_ready = 0 and the first result is held; raising box_ready loads the second result on the same edge, and box_valid stays 1.
REQ-037 Random pix_valid gaps (50%) on the REQ-033 image -> identical result; gap cycles do not advance the counters.
REQ-038 rst = 0 asserted mid-SCAN, then released and a clean frame sent -> outputs are 0 immediately on assertion; the next result matches that frame only.

Source files
------------

// File: rtl/palm_locator.sv
// palm_locator: finds the bounding box of foreground (skin) pixels in a
// binary frame streamed in raster order, and publishes it through a
// valid/ready result port. Frames with too few foreground pixels publish an
// all-zero box. An early sof aborts the current frame and restarts it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a sof transfer; non-sof pixels are discarded
// SCAN    | folding pixels of the current frame into the trackers
// PUBLISH | frame complete; waiting for a free result slot to load
module palm_locator #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int MIN_PIX = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_valid_i,
  output logic       pix_ready_o,
  input  logic       pix_data_i,
  input  logic       sof_i,
  output logic [7:0] start_of_palm_r_o,
  output logic [7:0] start_of_palm_c_o,
  output logic [7:0] end_of_palm_r_o,
  output logic [7:0] end_of_palm_c_o,
  output logic [7:0] palm_width_o,
  output logic [7:0] palm_height_o,
  output logic       box_valid_o,
  input  logic       box_ready_i,
  output logic       frame_err_o
);

  localparam logic [7:0]  COL_LAST  = 8'(IMG_W - 1);
  localparam logic [7:0]  ROW_LAST  = 8'(IMG_H - 1);
  localparam logic [15:0] MIN_PIX_L = 16'(MIN_PIX);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // Reset synchroniser: asserts asynchronously, releases two edges later.
  logic rst_meta_q;
  logic rst_n;

  // Two-flop release of the internal reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_meta_q <= 1'b0;
      rst_n      <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n      <= rst_meta_q;
    end
  end

  state_t      state_q;
  logic [7:0]  row_q, col_q;
  logic [7:0]  min_r_q, min_c_q, max_r_q, max_c_q;
  logic [15:0] cnt_q;
  logic [7:0]  sr_q, sc_q, er_q, ec_q, w_q, h_q;
  logic        box_valid_q;
  logic        frame_err_q;

  logic        xfer;
  logic        at_last;
  logic [7:0]  cur_r, cur_c;
  logic [7:0]  base_min_r, base_min_c, base_max_r, base_max_c;
  logic [15:0] base_cnt;
  logic [7:0]  min_r_d, min_c_d, max_r_d, max_c_d;
  logic [15:0] cnt_d;
  logic [7:0]  row_d, col_d;
  logic        res_ok;
  logic        pub_load;

  assign pix_ready_o = rst_n && (state_q != PUBLISH);
  assign xfer        = pix_valid_i && pix_ready_o;
  assign at_last     = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign res_ok      = (cnt_q >= MIN_PIX_L);
  assign pub_load    = (state_q == PUBLISH) && (!box_valid_q || box_ready_i);

  // Fold the offered pixel into the trackers; a sof pixel starts from empty at (0,0).
  always_comb begin
    cur_r      = sof_i ? 8'd0  : row_q;
    cur_c      = sof_i ? 8'd0  : col_q;
    base_min_r = sof_i ? 8'd0  : min_r_q;
    base_min_c = sof_i ? 8'd0  : min_c_q;
    base_max_r = sof_i ? 8'd0  : max_r_q;
    base_max_c = sof_i ? 8'd0  : max_c_q;
    base_cnt   = sof_i ? 16'd0 : cnt_q;

    min_r_d = base_min_r;
    min_c_d = base_min_c;
    max_r_d = base_max_r;
    max_c_d = base_max_c;
    cnt_d   = base_cnt;

    if (pix_data_i) begin
      if (base_cnt == 16'd0) begin
        // first foreground pixel of the frame defines the box alone
        min_r_d = cur_r;
        min_c_d = cur_c;
        max_r_d = cur_r;
        max_c_d = cur_c;
      end else begin
        if (cur_r < base_min_r) min_r_d = cur_r;
        if (cur_c < base_min_c) min_c_d = cur_c;
        if (cur_r > base_max_r) max_r_d = cur_r;
        if (cur_c > base_max_c) max_c_d = cur_c;
      end
      if (base_cnt != CNT_MAX) cnt_d = base_cnt + 16'd1;
    end

    if (cur_c == COL_LAST) begin
      col_d = 8'd0;
      row_d = cur_r + 8'd1;
    end else begin
      col_d = cur_c + 8'd1;
      row_d = cur_r;
    end
  end

  // Frame sequencing, tracker registers and the registered result port.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= 8'd0;
      col_q       <= 8'd0;
      min_r_q     <= 8'd0;
      min_c_q     <= 8'd0;
      max_r_q     <= 8'd0;
      max_c_q     <= 8'd0;
      cnt_q       <= 16'd0;
      sr_q        <= 8'd0;
      sc_q        <= 8'd0;
      er_q        <= 8'd0;
      ec_q        <= 8'd0;
      w_q         <= 8'd0;
      h_q         <= 8'd0;
      box_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // a consumed result empties the slot unless PUBLISH refills it below
      if (box_valid_q && box_ready_i) box_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (xfer && sof_i) begin
            min_r_q <= min_r_d;
            min_c_q <= min_c_d;
            max_r_q <= max_r_d;
            max_c_q <= max_c_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            state_q <= SCAN;
          end
        end

        SCAN: begin
          if (xfer) begin
            min_r_q <= min_r_d;
            min_c_q <= min_c_d;
            max_r_q <= max_r_d;
            max_c_q <= max_c_d;
            cnt_q   <= cnt_d;
            if (sof_i) begin
              // early sof: drop the partial frame, this pixel is (0,0) of a new one
              frame_err_q <= 1'b1;
              row_q       <= row_d;
              col_q       <= col_d;
            end else if (at_last) begin
              row_q   <= 8'd0;
              col_q   <= 8'd0;
              state_q <= PUBLISH;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end

        PUBLISH: begin
          if (pub_load) begin
            if (res_ok) begin
              sr_q <= min_r_q;
              sc_q <= min_c_q;
              er_q <= max_r_q;
              ec_q <= max_c_q;
              w_q  <= max_c_q - min_c_q + 8'd1;
              h_q  <= max_r_q - min_r_q + 8'd1;
            end else begin
              sr_q <= 8'd0;
              sc_q <= 8'd0;
              er_q <= 8'd0;
              ec_q <= 8'd0;
              w_q  <= 8'd0;
              h_q  <= 8'd0;
            end
            box_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_of_palm_r_o = sr_q;
  assign start_of_palm_c_o = sc_q;
  assign end_of_palm_r_o   = er_q;
  assign end_of_palm_c_o   = ec_q;
  assign palm_width_o      = w_q;
  assign palm_height_o     = h_q;
  assign box_valid_o       = box_valid_q;
  assign frame_err_o       = frame_err_q;

endmodule

// File: tb/tb_palm_locator.sv
// Bench for palm_locator: directed frames, a transaction-level reference
// model checked every cycle, and literal expectations for each scenario.
module tb_palm_locator;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int N    = W * H;
  localparam int MINP = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       pix_valid_i = 1'b0;
  logic       pix_ready_o;
  logic       pix_data_i = 1'b0;
  logic       sof_i = 1'b0;
  logic [7:0] start_of_palm_r_o, start_of_palm_c_o;
  logic [7:0] end_of_palm_r_o, end_of_palm_c_o;
  logic [7:0] palm_width_o, palm_height_o;
  logic       box_valid_o;
  logic       box_ready_i = 1'b1;
  logic       frame_err_o;

  palm_locator #(.IMG_W(W), .IMG_H(H), .MIN_PIX(MINP)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .pix_valid_i      (pix_valid_i),
    .pix_ready_o      (pix_ready_o),
    .pix_data_i       (pix_data_i),
    .sof_i            (sof_i),
    .start_of_palm_r_o(start_of_palm_r_o),
    .start_of_palm_c_o(start_of_palm_c_o),
    .end_of_palm_r_o  (end_of_palm_r_o),
    .end_of_palm_c_o  (end_of_palm_c_o),
    .palm_width_o     (palm_width_o),
    .palm_height_o    (palm_height_o),
    .box_valid_o      (box_valid_o),
    .box_ready_i      (box_ready_i),
    .frame_err_o      (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] dut_box();
    return {start_of_palm_r_o, start_of_palm_c_o, end_of_palm_r_o,
            end_of_palm_c_o, palm_width_o, palm_height_o};
  endfunction

  // Bounding box of a whole image, straight from its pixel map.
  function automatic logic [47:0] ref_box(input logic [N-1:0] img);
    int cnt = 0;
    int r0 = 255, c0 = 255, r1 = 0, c1 = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (img[r*W + c]) begin
          cnt++;
          if (r < r0) r0 = r;
          if (c < c0) c0 = c;
          if (r > r1) r1 = r;
          if (c > c1) c1 = c;
        end
    if (cnt < MINP) return 48'd0;
    return {8'(r0), 8'(c0), 8'(r1), 8'(c1), 8'(c1 - c0 + 1), 8'(r1 - r0 + 1)};
  endfunction

  // Transaction-level model: frame collector, one pending result, one result slot.
  logic [N-1:0] m_img = '0;
  int           m_pos = 0;
  bit           m_active = 0, m_pend = 0, m_bv = 0, m_ferr = 0;
  logic [47:0]  m_box = '0, m_pend_box = '0;
  int           m_rel = 0;
  bit           m_xf, m_load;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_img = '0; m_pos = 0; m_active = 0; m_pend = 0; m_bv = 0;
      m_ferr = 0; m_box = '0; m_pend_box = '0; m_rel = 0;
    end else begin
      m_xf   = pix_valid_i && (m_rel >= 2) && !m_pend;
      m_load = m_pend && (!m_bv || box_ready_i);
      m_ferr = 0;
      if (m_load) begin
        m_bv = 1; m_box = m_pend_box; m_pend = 0;
      end else if (m_bv && box_ready_i) begin
        m_bv = 0;
      end
      if (m_xf) begin
        if (sof_i) begin
          if (m_active) m_ferr = 1;
          m_img = '0; m_img[0] = pix_data_i; m_pos = 1; m_active = 1;
        end else if (m_active) begin
          m_img[m_pos] = pix_data_i;
          m_pos++;
          if (m_pos == N) begin
            m_pend_box = ref_box(m_img);
            m_pend = 1;
            m_active = 0;
          end
        end
      end
      if (m_rel < 2) m_rel++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    check("pix_ready", 48'(pix_ready_o), 48'(rst_ni && (m_rel >= 2) && !m_pend));
    check("box_valid", 48'(box_valid_o), 48'(m_bv));
    check("frame_err", 48'(frame_err_o), 48'(m_ferr));
    check("box_fields", dut_box(), m_box);
  end

  task automatic send_px(input bit s, input bit d);
    bit r = 0;
    pix_valid_i = 1'b1; sof_i = s; pix_data_i = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      r = pix_ready_o;
      @(posedge clk_i); #1;
      if (r) break;
    end
    if (!r) check("send_timeout", 48'd1, 48'd0);
    pix_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] img, input bit gaps, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1))
        repeat ($urandom_range(1, 2)) begin @(posedge clk_i); #1; end
      send_px(i == 0, img[i]);
    end
  endtask

  logic [N-1:0] img_a, img_b, img_c, img_d;
  localparam logic [47:0] BOX_A = {8'd1, 8'd2, 8'd3, 8'd5, 8'd4, 8'd3};
  localparam logic [47:0] BOX_C = {8'd0, 8'd1, 8'd5, 8'd7, 8'd7, 8'd6};
  localparam logic [47:0] BOX_D = {8'd4, 8'd0, 8'd5, 8'd1, 8'd2, 8'd2};

  initial begin
    img_a = '0; img_b = '0; img_c = '0; img_d = '0;
    for (int r = 1; r <= 3; r++) for (int c = 2; c <= 5; c++) img_a[r*W + c] = 1'b1;
    img_b[0] = 1'b1; img_b[2*W + 3] = 1'b1; img_b[5*W + 7] = 1'b1;
    for (int r = 0; r < H; r++) img_c[r*W + 7] = 1'b1;
    img_c[4*W + 1] = 1'b1;
    for (int r = 4; r <= 5; r++) for (int c = 0; c <= 1; c++) img_d[r*W + c] = 1'b1;

    // reset and synchronised release
    #1 rst_ni = 1'b0;
    #1;
    check("rst_pix_ready", 48'(pix_ready_o), 48'd0);
    check("rst_box_valid", 48'(box_valid_o), 48'd0);
    check("rst_box", dut_box(), 48'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("rel_edge1_ready", 48'(pix_ready_o), 48'd0);
    @(posedge clk_i); #1;
    check("rel_edge2_ready", 48'(pix_ready_o), 48'd1);

    // rectangle, no gaps, one-cycle latency
    send_frame(img_a, 0, 0, N - 1);
    check("a_not_yet_valid", 48'(box_valid_o), 48'd0);
    @(posedge clk_i); #1;
    check("a_valid", 48'(box_valid_o), 48'd1);
    check("a_box", dut_box(), BOX_A);

    // too few foreground pixels
    send_frame(img_b, 0, 0, N - 1);
    @(posedge clk_i); #1;
    check("b_valid", 48'(box_valid_o), 48'd1);
    check("b_box_zero", dut_box(), 48'd0);

    // early sof at pixel 20 restarts the frame
    send_frame(img_a, 0, 0, 19);
    send_px(1'b1, img_c[0]);
    check("err_pulse", 48'(frame_err_o), 48'd1);
    send_frame(img_c, 0, 1, N - 1);
    @(posedge clk_i); #1;
    check("c_valid", 48'(box_valid_o), 48'd1);
    check("c_box", dut_box(), BOX_C);

    // backpressure on the result port
    @(posedge clk_i); #1;
    box_ready_i = 1'b0;
    send_frame(img_a, 0, 0, N - 1);
    @(posedge clk_i); #1;
    check("hold_a_box", dut_box(), BOX_A);
    send_frame(img_c, 0, 0, N - 1);
    repeat (3) begin @(posedge clk_i); #1; end
    check("stall_ready", 48'(pix_ready_o), 48'd0);
    check("stall_valid", 48'(box_valid_o), 48'd1);
    check("stall_box_a", dut_box(), BOX_A);
    box_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("reload_valid", 48'(box_valid_o), 48'd1);
    check("reload_box_c", dut_box(), BOX_C);

    // random valid gaps
    send_frame(img_a, 1, 0, N - 1);
    @(posedge clk_i); #1;
    check("gap_valid", 48'(box_valid_o), 48'd1);
    check("gap_box", dut_box(), BOX_A);

    // reset mid-frame
    send_frame(img_c, 0, 0, 29);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", 48'(pix_ready_o), 48'd0);
    check("mid_rst_valid", 48'(box_valid_o), 48'd0);
    check("mid_rst_box", dut_box(), 48'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    send_frame(img_d, 0, 0, N - 1);
    @(posedge clk_i); #1;
    check("d_valid", 48'(box_valid_o), 48'd1);
    check("d_box_min_count", dut_box(), BOX_D);

    repeat (3) @(posedge clk_i);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
